// File: rtl/vram_arbiter.sv
// Frame-buffer RAM arbiter: display scan-out (absolute priority), one pixel writer, frame-clear engine.
// Optional double-buffering is enabled by defining VRAM_DBUF_EN.
module vram_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15,
  parameter int COLOR_W    = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               wr_valid,
  input  logic [7:0]         wr_x,
  input  logic [6:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
`ifdef VRAM_DBUF_EN
  input  logic               swap_req,
  output logic               disp_bank,
  output logic [ADDR_W:0]    mem_addr,
`else
  output logic [ADDR_W-1:0]  mem_addr,
`endif
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] pixel_rgb,
  output logic               pixel_valid
);

`ifdef VRAM_DBUF_EN
  localparam int MA_W = ADDR_W + 1;
`else
  localparam int MA_W = ADDR_W;
`endif

  localparam int                CELLS     = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

  // row * FB_W as a sum of shifted copies; FB_W is constant so this is a fixed adder tree
  function automatic logic [ADDR_W-1:0] row_base(input logic [ADDR_W-1:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++) begin
      if (((FB_W >> i) & 1) != 0) acc = acc + (row << i);
    end
    return acc;
  endfunction

  state_t               r_state;
  logic [ADDR_W-1:0]    r_clr_cnt;
  logic [COLOR_W-1:0]   r_clr_color;
  logic                 r_clear_busy;
  logic                 r_clear_done;
  logic [MA_W-1:0]      r_mem_addr;
  logic                 r_mem_we;
  logic [COLOR_W-1:0]   r_mem_wdata;
  logic                 r_slot_p0;
  logic                 r_slot_p1;
  logic                 r_vld_p0;
  logic                 r_vld_p1;
  logic [COLOR_W-1:0]   r_pixel_rgb;
  logic                 r_pixel_valid;

  logic                 w_slot;
  logic [ADDR_W-1:0]    w_disp_addr;
  logic [ADDR_W-1:0]    w_wr_addr;
  logic                 w_wr_inrange;
  logic                 w_wr_fire;
  logic [MA_W-1:0]      w_rd_full;
  logic [MA_W-1:0]      w_wr_full;
  logic [MA_W-1:0]      w_clr_full;

  assign w_slot       = video_on && (pixel_x[SCALE_LOG2-1:0] == '0);
  assign w_disp_addr  = row_base(ADDR_W'(pixel_y >> SCALE_LOG2)) + ADDR_W'(pixel_x >> SCALE_LOG2);
  assign w_wr_addr    = row_base(ADDR_W'(wr_y)) + ADDR_W'(wr_x);
  assign w_wr_inrange = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);

  // Reset gating keeps wr_ready low while the block is held in reset
  assign wr_ready  = reset_n && (r_state == ST_IDLE) && !w_slot;
  assign w_wr_fire = wr_valid && wr_ready;

`ifdef VRAM_DBUF_EN
  logic r_disp_bank;
  logic r_swap_pend;
  logic w_swap_point;

  assign w_swap_point = (pixel_y == 10'd480) && (pixel_x == 10'd0);
  assign w_rd_full    = {r_disp_bank, w_disp_addr};
  assign w_wr_full    = {~r_disp_bank, w_wr_addr};
  assign w_clr_full   = {~r_disp_bank, r_clr_cnt};
  assign disp_bank    = r_disp_bank;

  // Pending swaps merge; the bank flips at the start of vertical blanking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_disp_bank <= 1'b0;
      r_swap_pend <= 1'b0;
    end else if (w_swap_point && r_swap_pend) begin
      r_disp_bank <= ~r_disp_bank;
      r_swap_pend <= 1'b0;
    end else if (swap_req) begin
      r_swap_pend <= 1'b1;
    end
  end
`else
  assign w_rd_full  = w_disp_addr;
  assign w_wr_full  = w_wr_addr;
  assign w_clr_full = r_clr_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_clr_cnt     <= '0;
      r_clr_color   <= '0;
      r_clear_busy  <= 1'b0;
      r_clear_done  <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_wdata   <= '0;
      r_slot_p0     <= 1'b0;
      r_slot_p1     <= 1'b0;
      r_vld_p0      <= 1'b0;
      r_vld_p1      <= 1'b0;
      r_pixel_rgb   <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_mem_we     <= 1'b0;
      r_clear_done <= 1'b0;

      // p0: slot/video_on captured alongside the read address going out
      r_slot_p0 <= w_slot;
      r_vld_p0  <= video_on;
      // p1: RAM data for the slot arrives during this stage
      r_slot_p1 <= r_slot_p0;
      r_vld_p1  <= r_vld_p0;
      // p2: output register; colour is held across the remaining pixels of the cell
      r_pixel_valid <= r_vld_p1;
      if (!r_vld_p1) begin
        r_pixel_rgb <= '0;
      end else if (r_slot_p1) begin
        r_pixel_rgb <= mem_rdata;
      end

      if (w_slot) begin
        r_mem_addr <= w_rd_full;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_wr_fire && w_wr_inrange) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_wr_full;
            r_mem_wdata <= wr_data;
          end
          if (clear_req) begin
            r_state      <= ST_CLEAR;
            r_clr_cnt    <= '0;
            r_clr_color  <= clear_color;
            r_clear_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!w_slot) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_clr_full;
            r_mem_wdata <= r_clr_color;
            if (r_clr_cnt == LAST_CELL) begin
              r_state      <= ST_IDLE;
              r_clr_cnt    <= '0;
              r_clear_busy <= 1'b0;
              r_clear_done <= 1'b1;
            end else begin
              r_clr_cnt <= r_clr_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign clear_busy  = r_clear_busy;
  assign clear_done  = r_clear_done;
  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign pixel_rgb   = r_pixel_rgb;
  assign pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: writer path, scan-out latency, clear engine, range drop, reset abort.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic        wr_valid;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        clear_busy, clear_done;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] pixel_rgb;
  logic        pixel_valid;

  int n_cmp = 0;
  int n_err = 0;
  int bad;
  logic preload;
  logic [11:0] ram [0:32767];

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .clear_done(clear_done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pixel_rgb(pixel_rgb), .pixel_valid(pixel_valid)
  );

  // Single-port synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (preload) begin
      ram[0] <= 12'h000;
      ram[1] <= 12'h0F0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; preload = 1'b1;
    video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    clear_req = 1'b0; clear_color = '0;
    tick(); tick();
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rgb", 32'(pixel_rgb), 32'd0);
    chk("rst_pvalid", 32'(pixel_valid), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    preload = 1'b0; reset_n = 1'b1;

    // Blanking write (5,3) -> 3*160+5 = 485
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_data = 12'hF00;
    #1 chk("t1_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("t1_we", 32'(mem_we), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd485);
    chk("t1_wdata", 32'(mem_wdata), 32'hF00);
    wr_valid = 1'b0;
    tick();
    chk("t1_we_off", 32'(mem_we), 32'd0);
    chk("t1_addr_hold", 32'(mem_addr), 32'd485);

    // Active row 0 with writer (10,1) -> addr 170 competing for the RAM
    video_on = 1'b1; pixel_y = 10'd0;
    wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd1; wr_data = 12'h123;
    for (int x = 0; x < 8; x++) begin
      pixel_x = 10'(x);
      #1 chk("t2_ready", 32'(wr_ready), (x % 4 != 0) ? 32'd1 : 32'd0);
      tick();
      if (x % 4 == 0) begin
        chk("t2_rd_we", 32'(mem_we), 32'd0);
        chk("t2_rd_addr", 32'(mem_addr), 32'(x / 4));
      end else begin
        chk("t2_wr_we", 32'(mem_we), 32'd1);
        chk("t2_wr_addr", 32'(mem_addr), 32'd170);
      end
    end
    wr_valid = 1'b0;

    // Scan-out of row 0, cells 0 (0x000) and 1 (0x0F0); output 3 cycles after input
    for (int c = 0; c < 12; c++) begin
      pixel_x  = (c < 8) ? 10'(c) : 10'd0;
      video_on = (c < 8);
      tick();
      if (c >= 2) begin
        chk("t3_pvalid", 32'(pixel_valid), (c - 2 < 8) ? 32'd1 : 32'd0);
        chk("t3_rgb", 32'(pixel_rgb),
            (c - 2 >= 8) ? 32'h000 : ((c - 2 < 4) ? 32'h000 : 32'h0F0));
      end
    end

    // Full clear in blanking; colour latched at start, later changes ignored
    video_on = 1'b0; pixel_x = '0;
    clear_color = 12'h00F; clear_req = 1'b1;
    tick();
    clear_req = 1'b0; clear_color = 12'hABC;
    chk("t4_busy_start", 32'(clear_busy), 32'd1);
    chk("t4_we_start", 32'(mem_we), 32'd0);
    wr_valid = 1'b1; wr_x = 8'd1; wr_y = 7'd1; wr_data = 12'h321;
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (i == 5000) clear_req = 1'b1;
      if (i == 5001) clear_req = 1'b0;
      #1;
      if (wr_ready !== 1'b0) bad++;
      tick();
      if (mem_we !== 1'b1 || mem_addr !== 15'(i) || mem_wdata !== 12'h00F) bad++;
      if (clear_done !== (i == 19199)) bad++;
      if (clear_busy !== (i != 19199)) bad++;
    end
    chk("t4_clear_seq_errs", 32'(bad), 32'd0);
    chk("t4_done", 32'(clear_done), 32'd1);
    chk("t4_busy_end", 32'(clear_busy), 32'd0);
    chk("t4_last_addr", 32'(mem_addr), 32'd19199);
    wr_valid = 1'b0;
    tick();
    chk("t4_done_pulse", 32'(clear_done), 32'd0);
    chk("t4_we_after", 32'(mem_we), 32'd0);
    chk("t4_busy_after", 32'(clear_busy), 32'd0);

    // Range checks
    wr_valid = 1'b1; wr_x = 8'd0; wr_y = 7'd0; wr_data = 12'h111;
    tick();
    chk("t5_base_we", 32'(mem_we), 32'd1);
    chk("t5_base_addr", 32'(mem_addr), 32'd0);
    wr_x = 8'd160; wr_y = 7'd0; wr_data = 12'h555;
    #1 chk("t5_oor_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("t5_oorx_we", 32'(mem_we), 32'd0);
    chk("t5_oorx_addr", 32'(mem_addr), 32'd0);
    wr_x = 8'd0; wr_y = 7'd120;
    tick();
    chk("t5_oory_we", 32'(mem_we), 32'd0);
    wr_x = 8'd159; wr_y = 7'd119; wr_data = 12'h777;
    tick();
    chk("t5_max_we", 32'(mem_we), 32'd1);
    chk("t5_max_addr", 32'(mem_addr), 32'd19199);
    chk("t5_max_wdata", 32'(mem_wdata), 32'h777);
    wr_valid = 1'b0;
    tick();

    // Reset mid-clear at counter 1000
    clear_color = 12'h0C0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    bad = 0;
    for (int i = 0; i <= 1000; i++) begin
      tick();
      if (mem_addr !== 15'(i) || mem_we !== 1'b1) bad++;
    end
    chk("t6_pre_errs", 32'(bad), 32'd0);
    chk("t6_pre_busy", 32'(clear_busy), 32'd1);
    reset_n = 1'b0;
    #1 chk("t6_rst_ready", 32'(wr_ready), 32'd0);
    tick();
    chk("t6_rst_addr", 32'(mem_addr), 32'd0);
    chk("t6_rst_we", 32'(mem_we), 32'd0);
    chk("t6_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("t6_rst_rgb", 32'(pixel_rgb), 32'd0);
    chk("t6_rst_pvalid", 32'(pixel_valid), 32'd0);
    chk("t6_rst_busy", 32'(clear_busy), 32'd0);
    chk("t6_rst_done", 32'(clear_done), 32'd0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (clear_done !== 1'b0 || clear_busy !== 1'b0 || mem_we !== 1'b0) bad++;
    end
    chk("t6_post_quiet", 32'(bad), 32'd0);

    // Write and clear request together: write taken, clear restarts from 0 next
    wr_valid = 1'b1; wr_x = 8'd2; wr_y = 7'd0; wr_data = 12'h222;
    clear_req = 1'b1; clear_color = 12'h0A0;
    #1 chk("t6_both_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("t6_both_we", 32'(mem_we), 32'd1);
    chk("t6_both_addr", 32'(mem_addr), 32'd2);
    chk("t6_both_busy", 32'(clear_busy), 32'd1);
    wr_valid = 1'b0; clear_req = 1'b0;
    tick();
    chk("t6_restart_addr0", 32'(mem_addr), 32'd0);
    chk("t6_restart_we", 32'(mem_we), 32'd1);
    chk("t6_restart_wdata", 32'(mem_wdata), 32'h0A0);
    tick();
    chk("t6_restart_addr1", 32'(mem_addr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Owns the single-port frame-buffer RAM, a 160x120 image in 12-bit RGB444 shown at 4x4 pixel scale on the 640x480 display. It shares the RAM between the display scan-out and one pixel-writer client; the scan-out has absolute priority. It also runs a frame-clear engine. It sits between the VGA timing generator (pixel_x/pixel_y/video_on), the game-logic writer and the RAM.

Parameters:
FB_W, 160, frame-buffer width in cells
FB_H, 120, frame-buffer height in cells
SCALE_LOG2, 2, log2 of display pixels per cell in each axis
ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H
COLOR_W, 12, pixel data width

Ports:
clk  in  1  pixel clock, rising edge
reset_n  in  1  synchronous, active-low reset
video_on  in  1  display-active flag from the timing generator
pixel_x  in  10  current display column
pixel_y  in  10  current display row
wr_valid  in  1  writer request
wr_x  in  8  target cell column
wr_y  in  7  target cell row
wr_data  in  COLOR_W  cell colour
wr_ready  out  1  write accepted this cycle (combinational)
clear_req  in  1  start frame clear (level sampled each cycle)
clear_color  in  COLOR_W  fill colour, sampled when the clear starts
clear_busy  out  1  clear in progress
clear_done  out  1  one-cycle pulse after the last clear write
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  COLOR_W  RAM write data (registered)
mem_rdata  in  COLOR_W  RAM read data, valid 1 cycle after the address is sampled
pixel_rgb  out  COLOR_W  colour to the DAC
pixel_valid  out  1  pixel_rgb is in the active area

Behaviour:
- Reset (reset_n=0 at an edge): all outputs 0, FSM to IDLE, clear counter 0, delay pipes 0. RAM contents are not touched.
- Display slot: a cycle where video_on=1 and pixel_x[SCALE_LOG2-1:0]==0. In a display slot the next-cycle mem_addr = (pixel_y>>SCALE_LOG2)*FB_W + (pixel_x>>SCALE_LOG2) and mem_we=0.
  - Computed with shifts/adds; no multiplier.
- Non-slot cycles are free for the writer or the clear engine. If neither uses a free cycle, mem_we=0 and mem_addr holds its value.
- Display latency is 3 cycles from pixel_x/pixel_y/video_on to pixel_rgb/pixel_valid. Downstream delays hsync/vsync by 3 to match.
  - The slot flag and video_on each pass through a 3-stage delay pipe.
  - pixel_rgb loads mem_rdata on a delayed slot.
  - pixel_rgb holds its value for the following 3 pixels of the cell.
  - pixel_rgb is forced to 0 when delayed video_on=0.
  - pixel_valid = delayed video_on.
- FSM IDLE:
  - wr_ready = !display_slot.
  - A handshake (wr_valid && wr_ready) at edge t drives mem_we=1, mem_addr=wr_y*FB_W+wr_x and mem_wdata=wr_data in cycle t+1.
  - Out-of-range writes (wr_x>=FB_W or wr_y>=FB_H) still complete the handshake, but are dropped with mem_we=0.
  - clear_req=1 moves to CLEAR: latch clear_color, counter=0, clear_busy=1.
  - If wr_valid and clear_req are both asserted in the same cycle, the write is accepted and the clear starts next cycle.
- FSM CLEAR:
  - wr_ready=0 and clear_req is ignored.
  - On each free cycle, write the latched colour at the counter address, then increment the counter.
  - After the write of address FB_W*FB_H-1, the FSM goes to IDLE on the same edge, clear_busy falls and clear_done pulses for 1 cycle.
  - A clear uses exactly FB_W*FB_H writes. Throughput is 3 of 4 cycles in active video and 1 per cycle in blanking.
- Reset mid-clear aborts the clear: the FSM goes to IDLE with no clear_done, and the RAM is left partially cleared.
- The writer must hold wr_* stable while wr_valid=1 and wr_ready=0.

Optional Feature:
VRAM_DBUF_EN
- Defined:
  - mem_addr gains 1 MSB (bank bit).
  - Adds input swap_req and output disp_bank (reset 0).
  - Scan-out reads bank disp_bank; writer and clear engine target bank ~disp_bank.
  - A swap_req pulse sets a pending flag. disp_bank toggles, and the flag clears, on the first cycle with pixel_y==480 and pixel_x==0.
  - A swap request arriving while a swap is already pending is merged with it.
- Undefined: single bank, no swap logic, mem_addr is ADDR_W bits.

Test Plan:
1. Blanking (video_on=0), write (wr_x=5, wr_y=3, wr_data=0xF00) -> wr_ready=1; next cycle mem_we=1, mem_addr=485, mem_wdata=0xF00.
2. video_on=1, pixel_y=0, pixel_x=0..7, wr_valid held -> wr_ready=0 at x=0 and x=4. Reads of addr 0 and 1 are issued, writes go in the other cycles, no collision.
3. RAM addr 1 preloaded with 0x0F0 and addr 0 with 0x000, scan pixel_x=0..7 on row 0 -> pixel_rgb=0x000 for 4 cycles, then 0x0F0 for 4 cycles, starting 3 cycles after x=0. pixel_valid tracks video_on delayed 3.
4. clear_req with clear_color=0x00F in blanking -> 19200 consecutive writes covering addr 0..19199, then a single clear_done pulse. wr_ready=0 throughout. A clear_req mid-clear is ignored.
5. Write wr_x=160, wr_y=0 -> handshake completes, mem_we stays 0. Then write wr_x=159, wr_y=119 -> mem_addr=19199.
6. reset_n=0 for 1 cycle mid-clear at counter 1000 -> all outputs 0, clear_busy=0, no clear_done. The next clear_req restarts from addr 0.
